// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl: read-modify-write controller merging SW/SH/SB stores into aligned memory words
module store_merge_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [1:0] op, lane;
  logic [31:0] data, word, sh_word, sb_word;
  // insert the captured store lane into the captured read word; SW passes data straight through
  always_comb begin
    sh_word = (word & ~(32'hffff << {lane[1], 4'b0})) | ({16'h0, data[15:0]} << {lane[1], 4'b0});
    sb_word = (word & ~(32'hff << {lane, 3'b0})) | ({24'h0, data[7:0]} << {lane, 3'b0});
    mem_wdata = op == 2'b01 ? sh_word : op == 2'b10 ? sb_word : data;
  end
  // store sequencer with registered strobes; misaligned and reserved requests go straight to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      lane <= '0;
      data <= '0;
      word <= '0;
      mem_addr <= '0;
      mem_wr <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op <= st_op;
          lane <= st_addr[1:0];
          data <= st_data;
          mem_addr <= {st_addr[31:2], 2'b00};
          busy <= 1'b1;
          if (st_op == 2'b00 && st_addr[1:0] == 2'b00) begin
            state <= WRITE;
            mem_wr <= 1'b1;
          end else if ((st_op == 2'b01 && !st_addr[0]) || st_op == 2'b10) begin
            state <= READ;
          end else begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          word <= mem_rdata;
          state <= WRITE;
          mem_wr <= 1'b1;
        end
        WRITE: begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_merge_ctrl.sv
// tb_store_merge_ctrl: scoreboard bench for store_merge_ctrl with directed store vectors
module tb_store_merge_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] st_op = '0;
  logic [31:0] st_addr = '0, st_data = '0, mem_rdata = 32'hBAD0BAD0;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_wr, busy, done, err;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; int cyc;} wexp_t;
  typedef struct packed {logic e; int cyc;} dexp_t;
  typedef struct packed {logic [1:0] op; logic [31:0] addr, data, rd, waddr, wdata; logic e; int lat;} vec_t;
  wexp_t wq[$];
  dexp_t dq[$];
  wexp_t w;
  dexp_t d;
  vec_t vecs[12];

  store_merge_ctrl dut (.clk(clk), .reset(reset), .start(start), .st_op(st_op), .st_addr(st_addr),
    .st_data(st_data), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (mem_wr) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none", mem_addr, mem_wdata);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual err=%b required none", err);
      end else begin
        d = dq.pop_front();
        chk("done_err", {31'b0, err}, {31'b0, d.e});
        chk("done_cycle", cyc, d.cyc);
      end
    end
    if (err && !done) begin
      checks++; failures++;
      $display("FAIL err_without_done actual=1 required=0");
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    chk("drain", wq.size() + dq.size(), 0);
    @(negedge clk);
  endtask

  task automatic issue(input vec_t v, output int c);
    @(negedge clk);
    start = 1'b1; st_op = v.op; st_addr = v.addr; st_data = v.data; c = cyc;
    if (!v.e) wq.push_back('{v.waddr, v.wdata, c + v.lat - 1});
    dq.push_back('{v.e, c + v.lat});
  endtask

  task automatic run(input vec_t v);
    int c;
    issue(v, c);
    @(negedge clk); start = 1'b0;
    @(negedge clk); mem_rdata = v.rd;
    @(negedge clk); mem_rdata = 32'hBAD0BAD0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vecs = '{
      '{2'b00, 32'h00000100, 32'hDEADBEEF, 32'h0,        32'h00000100, 32'hDEADBEEF, 1'b0, 2},
      '{2'b10, 32'h00000203, 32'h000000AB, 32'h11223344, 32'h00000200, 32'hAB223344, 1'b0, 4},
      '{2'b01, 32'h00000302, 32'h0000CAFE, 32'h11223344, 32'h00000300, 32'hCAFE3344, 1'b0, 4},
      '{2'b01, 32'h00000300, 32'hFFFF1234, 32'h11223344, 32'h00000300, 32'h11221234, 1'b0, 4},
      '{2'b10, 32'h00000200, 32'hFFFFFF55, 32'h11223344, 32'h00000200, 32'h11223355, 1'b0, 4},
      '{2'b10, 32'h00000201, 32'h00000066, 32'h11223344, 32'h00000200, 32'h11226644, 1'b0, 4},
      '{2'b10, 32'h00000202, 32'h00000077, 32'h11223344, 32'h00000200, 32'h11773344, 1'b0, 4},
      '{2'b01, 32'h00000301, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h0,        1'b1, 1},
      '{2'b11, 32'h00000400, 32'h12345678, 32'h11223344, 32'h0,        32'h0,        1'b1, 1},
      '{2'b00, 32'h00000102, 32'h12345678, 32'h11223344, 32'h0,        32'h0,        1'b1, 1},
      '{2'b00, 32'h0FFFFFFC, 32'hA5A5A5A5, 32'h0,        32'h0FFFFFFC, 32'hA5A5A5A5, 1'b0, 2},
      '{2'b10, 32'hFFFFFFFF, 32'h00000099, 32'h01020304, 32'hFFFFFFFC, 32'h99020304, 1'b0, 4}
    };
    #2;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run(vecs[i]);
    issue('{2'b10, 32'h00000201, 32'h000000EE, 32'hAABBCCDD, 32'h00000200, 32'hAABBEEDD, 1'b0, 4}, c);
    @(negedge clk);
    chk("busy_high", {31'b0, busy}, 1);
    st_op = 2'b00; st_addr = 32'h00000500; st_data = 32'h12345678;
    @(negedge clk); mem_rdata = 32'hAABBCCDD;
    @(negedge clk); mem_rdata = 32'hBAD0BAD0; start = 1'b0;
    drain();
    issue(vecs[0], c);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; st_op = 2'b00; st_addr = 32'h00000600; st_data = 32'h0BADF00D;
    @(negedge clk); start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("idle_after_done_start", {31'b0, busy}, 0);
    issue(vecs[1], c);
    wq.delete(); dq.delete();
    @(negedge clk); start = 1'b0;
    @(negedge clk); mem_rdata = 32'h11223344;
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_mem_wr", {31'b0, mem_wr}, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    @(negedge clk); mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    run(vecs[0]);
    repeat (6) @(negedge clk);
    chk("final_queues", wq.size() + dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_merge_ctrl.md
STORE_MERGE_CTRL -- requirements
Module: store_merge_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports are clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  single-cycle store request; sampled only in IDLE.
REQ-005 st_op  input  2  store size: 00=SW, 01=SH, 10=SB, 11=reserved (treated as error).
REQ-006 st_addr  input  32  byte address of the store; captured with start.
REQ-007 st_data  input  32  register data to store; captured with start.
REQ-008 mem_addr  output  32  word address to memory: captured st_addr with bits [1:0] forced to 00.
REQ-009 mem_wr  output  1  memory write strobe.
REQ-010 mem_wdata  output  32  merged word to write.
REQ-011 mem_rdata  input  32  memory read data, valid one cycle after mem_addr is presented with mem_wr=0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a store completes or aborts.
REQ-014 err  output  1  held high with done on misaligned or reserved requests; otherwise 0.

Function
REQ-015 FSM states SHALL be IDLE, READ, WAIT, WRITE and DONE.
REQ-016 In IDLE, if start=1, the block SHALL capture st_op, st_addr and st_data.
REQ-017 After capture in IDLE, the next state SHALL be:
- WRITE for SW with addr[1:0]=00;
- READ for SH with addr[0]=0, or for SB;
- DONE with err=1 for any other case.
REQ-018 Misaligned cases are SW with addr[1:0]≠00 and SH with addr[0]=1; these, like st_op=11, go to DONE with err=1.
REQ-019 The READ state SHALL drive mem_addr with mem_wr=0 and then go to WAIT.
REQ-020 The WAIT state SHALL register mem_rdata into an internal word register and then go to WRITE.
REQ-021 The WRITE state SHALL assert mem_wr=1 for exactly one cycle with mem_wdata equal to the merged word, then go to DONE.
REQ-022 Merge rules use little-endian lanes:
- SW: mem_wdata = st_data.
- SH: bits [16*a1+15 : 16*a1] = st_data[15:0], where a1 = addr[1]; the remaining bits come from the captured read word.
- SB: bits [8*a+7 : 8*a] = st_data[7:0], where a = addr[1:0]; the remaining bits come from the captured read word.
REQ-023 The DONE state SHALL assert done=1 for one cycle and then return to IDLE.
REQ-024 err SHALL be valid only while done=1 and SHALL be 0 at all other times.
REQ-025 Latency from the start edge to the done cycle SHALL be:
- 2 cycles for SW;
- 4 cycles for SH and SB;
- 1 cycle for errors.
REQ-026 start SHALL be ignored while busy=1; no request is queued.
REQ-027 A start in the same cycle that DONE returns to IDLE is not accepted; it is accepted only when the FSM is in IDLE.
REQ-028 mem_wr SHALL never be asserted in IDLE, READ, WAIT or DONE, and never on error paths.
REQ-029 mem_addr SHALL remain stable from READ through WRITE.

Reset
REQ-030 While reset=1, the FSM SHALL be in IDLE and busy, done, err and mem_wr SHALL be 0.
REQ-031 While reset=1, mem_addr, mem_wdata and the internal registers SHALL be 0.
REQ-032 Reset asserted during any state SHALL abort the operation immediately. No write occurs after reset assertion, and no done pulse is produced for the aborted request.

Verification
REQ-033 SW check: start, st_op=00, st_addr=0x100, st_data=0xDEADBEEF -> the next cycle has mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; the cycle after has done=1, err=0.
REQ-034 SB check: st_op=10, st_addr=0x203, st_data=0x000000AB, mem_rdata=0x11223344 -> one WRITE cycle with mem_addr=0x200 and mem_wdata=0xAB223344; done follows with err=0.
REQ-035 SH check: st_op=01, st_addr=0x302, st_data=0x0000CAFE, mem_rdata=0x11223344 -> mem_wdata=0xCAFE3344.
REQ-036 Error check: SH with st_addr=0x301, and separately st_op=11 -> done=1 and err=1 the cycle after start, with mem_wr=0 throughout.
REQ-037 Busy check: a second start issued while busy=1 is ignored, giving exactly one mem_wr pulse and one done pulse.
REQ-038 Reset-abort check: reset asserted during WAIT of an SB request -> mem_wr stays 0, no done pulse, and busy=0 immediately; a new SW request after reset release completes normally.
